// File: rtl/pri_encoder_hs.sv
// Registered priority encoder with sticky request capture, per-line masking,
// fixed or round-robin arbitration and a valid/ready output handshake.
module pri_encoder_hs #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N-1:0]     data_in,
    input  logic [N-1:0]     mask,
    input  logic             rr_mode,
    output logic [IDX_W-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic             irq
);

    localparam int unsigned LAST_IDX = N - 1;

    logic [N-1:0]     pending_q,   pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] data_out_q,  data_out_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;

    logic             accept_c;
    logic             slot_free_c;
    logic [N-1:0]     clr_vec_c;
    logic [N-1:0]     elig_c;
    logic [IDX_W-1:0] fixed_win_c;
    logic [IDX_W-1:0] rr_win_c;

    // Handshake, clear vector and eligible set from the current registers
    always_comb begin
        accept_c    = out_valid_q & out_ready;
        slot_free_c = ~out_valid_q | accept_c;
        clr_vec_c   = '0;
        if (accept_c) begin
            clr_vec_c[data_out_q] = 1'b1;
        end
        elig_c = pending_q & ~mask & ~clr_vec_c;
    end

    // Fixed priority: later (higher) indices overwrite, so the highest set bit wins
    always_comb begin
        fixed_win_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (elig_c[IDX_W'(i)]) begin
                fixed_win_c = IDX_W'(i);
            end
        end
    end

    // Round-robin: scan distance N-1 down to 0 below ptr so the nearest set bit wins
    always_comb begin
        int unsigned p;
        int unsigned idx;
        p        = 32'(ptr_q);
        idx      = 0;
        rr_win_c = '0;
        for (int unsigned k = N; k > 0; k--) begin
            idx = (p >= (k - 1)) ? (p - (k - 1)) : (p + N - (k - 1));
            if (elig_c[IDX_W'(idx)]) begin
                rr_win_c = IDX_W'(idx);
            end
        end
    end

    // Next-state: sticky capture (set beats clear), selection into a free slot, pointer rotate
    always_comb begin
        pending_d   = (pending_q & ~clr_vec_c) | (data_in & {N{enable}});
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        ptr_d       = ptr_q;

        if (slot_free_c) begin
            if (enable && (|elig_c)) begin
                out_valid_d = 1'b1;
                data_out_d  = rr_mode ? rr_win_c : fixed_win_c;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (accept_c && rr_mode) begin
            ptr_d = (data_out_q == '0) ? IDX_W'(LAST_IDX) : (data_out_q - IDX_W'(1));
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            ptr_q       <= IDX_W'(LAST_IDX);
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            ptr_q       <= ptr_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign irq       = |(pending_q & ~mask);

endmodule
